// File: rtl/cla_adder_pkg.sv
// Shared types and constants for the carry-lookahead adder slice.
// Package name: cla_pkg.
package cla_pkg;

    // Bits per first-level lookahead group.
    localparam int GROUP_W = 4;

    // One group's worth of operand bits.
    typedef logic [GROUP_W-1:0] grp_vec_t;

    // Group generate/propagate pair handed to the second-level carry unit.
    typedef struct packed {
        logic gg;
        logic gp;
    } pg_t;

endpackage : cla_pkg

// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder. The driver uses the master modport and
// the adder uses the slave modport.
interface cla_adder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   s;

    modport master (output x, output y, input s);
    modport slave  (input x, input y, output s);
endinterface : cla_adder_if

// File: rtl/cla_adder_cla4.sv
// cla4_block: purely combinational 4-bit carry-lookahead group. Produces the
// group sum from a supplied carry-in, plus the group generate/propagate pair
// for the next lookahead level. All internal carries are fully expanded.
module cla4_block
    import cla_pkg::*;
(
    input  grp_vec_t a,
    input  grp_vec_t b,
    input  logic     cin,
    output grp_vec_t sum,
    output logic     gg,
    output logic     gp
);

    grp_vec_t g_s;
    grp_vec_t p_s;
    grp_vec_t c_s;

    // Bit-level generate/propagate and expanded internal carries.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s    = 4'b0000;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
    end

    // Sum bits and group generate/propagate.
    always_comb begin
        sum = p_s ^ c_s;
        gg  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
            | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        gp  = p_s[3] & p_s[2] & p_s[1] & p_s[0];
    end

endmodule : cla4_block

// File: rtl/cla_adder.sv
// cla_adder: registered unsigned two-level carry-lookahead adder.
// s = x + y, width WIDTH+1, carry-out in the MSB. Latency is 1 cycle.
// Optional macro CLA_ADDER_IN_REG_EN adds operand input registers
// (latency 2, throughput unchanged).
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    cla_adder_if.slave    bus
);

    localparam int   NG = WIDTH / GROUP_W;
    localparam logic C0 = 1'b0;  // the adder has no carry-in

    if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_width_chk
        $error("cla_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [WIDTH-1:0] op_x_s;
    logic [WIDTH-1:0] op_y_s;

`ifdef CLA_ADDER_IN_REG_EN
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    // Next value for the operand registers is simply the current inputs.
    always_comb begin
        x_d = bus.x;
        y_d = bus.y;
    end

    // Operand capture; reset clears so X on the inputs cannot leak through.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign op_x_s = x_q;
    assign op_y_s = y_q;
`else
    assign op_x_s = bus.x;
    assign op_y_s = bus.y;
`endif

    pg_t  [NG-1:0]    grp_pg_s;
    logic [NG:0]      gc_s;      // gc_s[j] = carry into group j, gc_s[NG] = carry-out
    logic [WIDTH-1:0] sum_s;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4_block u_cla4 (
            .a   (op_x_s[gi*GROUP_W +: GROUP_W]),
            .b   (op_y_s[gi*GROUP_W +: GROUP_W]),
            .cin (gc_s[gi]),
            .sum (sum_s[gi*GROUP_W +: GROUP_W]),
            .gg  (grp_pg_s[gi].gg),
            .gp  (grp_pg_s[gi].gp)
        );
    end

    // Second-level lookahead: each group carry is an OR of expanded GG/GP
    // products, never derived from the previous group carry.
    always_comb begin : p_group_carry
        logic term_s;
        gc_s    = '0;
        term_s  = 1'b0;
        gc_s[0] = C0;
        for (int j = 0; j < NG; j++) begin
            term_s = C0;
            for (int k = 0; k <= j; k++) begin
                term_s = term_s & grp_pg_s[k].gp;
            end
            gc_s[j+1] = term_s;
            for (int k = 0; k <= j; k++) begin
                term_s = grp_pg_s[k].gg;
                for (int m = k + 1; m <= j; m++) begin
                    term_s = term_s & grp_pg_s[m].gp;
                end
                gc_s[j+1] = gc_s[j+1] | term_s;
            end
        end
    end

    logic [WIDTH:0] s_q;
    logic [WIDTH:0] s_d;

    // Result next-state: carry-out above the group sums.
    always_comb begin
        s_d = {gc_s[NG], sum_s};
    end

    // Result register; reset wins over new operands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign bus.s = s_q;

endmodule : cla_adder

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: one WIDTH=4 and one WIDTH=16 instance
// driven in lockstep, each compared every cycle against a delayed expected sum.
module tb_cla_adder;

`ifdef CLA_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cla_adder_if #(.WIDTH(4))  if4  ();
    cla_adder_if #(.WIDTH(16)) if16 ();

    cla_adder #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    cla_adder #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] pipe4  [LAT];
    logic [16:0] pipe16 [LAT];

    task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; e4/e16 are the sums expected for these operands.
    task automatic tick(input logic r,
                        input logic [3:0] x4, input logic [3:0] y4, input logic [4:0] e4,
                        input logic [15:0] x16, input logic [15:0] y16, input logic [16:0] e16,
                        input string tag);
        rst    = r;
        if4.x  = x4;
        if4.y  = y4;
        if16.x = x16;
        if16.y = y16;
        @(posedge clk);
        for (int k = LAT - 1; k > 0; k--) begin
            pipe4[k]  = r ? 17'd0 : pipe4[k-1];
            pipe16[k] = r ? 17'd0 : pipe16[k-1];
        end
        pipe4[0]  = r ? 17'd0 : {12'd0, e4};
        pipe16[0] = r ? 17'd0 : e16;
        #1;
        check_val({tag, "/w4"},  {12'd0, if4.s}, pipe4[LAT-1]);
        check_val({tag, "/w16"}, if16.s,         pipe16[LAT-1]);
    endtask

    logic [3:0]  dx4 [8];
    logic [3:0]  dy4 [8];
    logic [4:0]  de4 [8];
    logic [15:0] dx16 [8];
    logic [15:0] dy16 [8];
    logic [16:0] de16 [8];

    initial begin
        for (int k = 0; k < LAT; k++) begin
            pipe4[k]  = 17'd0;
            pipe16[k] = 17'd0;
        end

        // Hand-computed directed vectors.
        dx4[0] = 4'h8; dy4[0] = 4'h3; de4[0] = 5'h0B; dx16[0] = 16'hFFFF; dy16[0] = 16'h0001; de16[0] = 17'h10000;
        dx4[1] = 4'h1; dy4[1] = 4'hA; de4[1] = 5'h0B; dx16[1] = 16'hFFFF; dy16[1] = 16'hFFFF; de16[1] = 17'h1FFFE;
        dx4[2] = 4'h6; dy4[2] = 4'h6; de4[2] = 5'h0C; dx16[2] = 16'h1234; dy16[2] = 16'h4321; de16[2] = 17'h05555;
        dx4[3] = 4'h9; dy4[3] = 4'h6; de4[3] = 5'h0F; dx16[3] = 16'h8000; dy16[3] = 16'h8000; de16[3] = 17'h10000;
        dx4[4] = 4'h9; dy4[4] = 4'h4; de4[4] = 5'h0D; dx16[4] = 16'hABCD; dy16[4] = 16'h1111; de16[4] = 17'h0BCDE;
        dx4[5] = 4'hF; dy4[5] = 4'hE; de4[5] = 5'h1D; dx16[5] = 16'h0FFF; dy16[5] = 16'h0001; de16[5] = 17'h01000;
        dx4[6] = 4'hF; dy4[6] = 4'h1; de4[6] = 5'h10; dx16[6] = 16'h00FF; dy16[6] = 16'hFF01; de16[6] = 17'h10000;
        dx4[7] = 4'h0; dy4[7] = 4'h0; de4[7] = 5'h00; dx16[7] = 16'h0000; dy16[7] = 16'h0000; de16[7] = 17'h00000;

        // Reset with unknown operands, then with all-ones operands.
        tick(1'b1, 4'bx, 4'bx, 5'd0, 16'bx, 16'bx, 17'd0, "rst_x");
        tick(1'b1, 4'bx, 4'bx, 5'd0, 16'bx, 16'bx, 17'd0, "rst_x");
        tick(1'b1, 4'hF, 4'hF, 5'd0, 16'hFFFF, 16'hFFFF, 17'd0, "rst_ones");
        tick(1'b1, 4'hF, 4'hF, 5'd0, 16'hFFFF, 16'hFFFF, 17'd0, "rst_ones");

        // Release: all-ones + all-ones appears after the pipeline latency.
        for (int i = 0; i < LAT; i++) begin
            tick(1'b0, 4'hF, 4'hF, 5'h1E, 16'hFFFF, 16'hFFFF, 17'h1FFFE, "release");
        end

        // Directed vectors including the full-carry and zero corners.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, dx4[i], dy4[i], de4[i], dx16[i], dy16[i], de16[i], $sformatf("dir%0d", i));
        end

        // Back-to-back stream with a one-cycle reset in the middle.
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  a4;
            logic [3:0]  b4;
            logic [15:0] a16;
            logic [15:0] b16;
            a4  = 4'(i);
            b4  = 4'((i * 7 + 3) % 16);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            tick((i == 8) ? 1'b1 : 1'b0, a4, b4, {1'b0, a4} + {1'b0, b4},
                 a16, b16, {1'b0, a16} + {1'b0, b16}, $sformatf("stream%0d", i));
        end

        // Exhaustive WIDTH=4 pairs; the wide adder sees random operands.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0]  a4;
                logic [3:0]  b4;
                logic [15:0] a16;
                logic [15:0] b16;
                a4  = 4'(a);
                b4  = 4'(b);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                tick(1'b0, a4, b4, {1'b0, a4} + {1'b0, b4},
                     a16, b16, {1'b0, a16} + {1'b0, b16}, "exh");
            end
        end

        // Random WIDTH=16 pairs.
        for (int i = 0; i < 10000; i++) begin
            logic [3:0]  a4;
            logic [3:0]  b4;
            logic [15:0] a16;
            logic [15:0] b16;
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            tick(1'b0, a4, b4, {1'b0, a4} + {1'b0, b4},
                 a16, b16, {1'b0, a16} + {1'b0, b16}, "rnd");
        end

        // Drain the pipeline with a final full-carry pair.
        for (int i = 0; i < LAT; i++) begin
            tick(1'b0, 4'hF, 4'h1, 5'h10, 16'hFFFF, 16'h0001, 17'h10000, "tail");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cla_adder
